// File: rtl/block_swap_engine_pkg.sv
// Shared constants and state encoding for the block swap engine.
// Block addresses are 21 bits (addr[31:11]); an all-ones block address marks an empty slot.
// The swap engine walks the states below once per requested swap.
package block_swap_engine_pkg;

   localparam int unsigned BLOCK_ADDR_W   = 21;
   localparam int unsigned BLOCK_OFFSET_W = 11;
   localparam logic [BLOCK_ADDR_W-1:0] INVALID_BLOCK_ADDR = 21'h1F_FFFF;

   typedef enum logic [3:0] {
      IDLE,
      WB_RD,
      WB_RWAIT,
      WB_WR,
      WB_WWAIT,
      FE_RD,
      FE_RWAIT,
      FE_WR,
      FE_WWAIT,
      DONE
   } swap_state_e;

endpackage

// File: rtl/block_swap_engine.sv
// Block swap engine: writes an evicted SRAM slot back to external memory, then fetches the
// requested block into that slot, then pulses done_o for one cycle.
// Latency: 4 cycles/word/phase on a zero-wait bus; full swap 8*BLOCK_WORDS+2, empty slot 4*BLOCK_WORDS+2.
// Backpressure: each request is held with stable addr/we/wdata until gnt; one outstanding access per port.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   swap_req_i                    level request from the blocker, sampled only in IDLE
//   old_addr_idx_i/old_addr_i     slot to replace and the block it holds (INVALID_BLOCK_ADDR = empty)
//   new_addr_i                    block to fetch into the slot
//   done_o, busy_o                one-cycle completion pulse, engine-active flag
//   sram_* / ext_*                OBI-style manager ports (req/we/addr/wdata out, gnt/rvalid/rdata in)
module block_swap_engine
   import block_swap_engine_pkg::*;
#(
   parameter int unsigned NUM_SRAM_ADDRESSES = 4,
   parameter int unsigned BLOCK_WORDS        = 512,
   parameter logic [31:0] SRAM_BASE          = 32'h1000_0000,
   parameter logic [31:0] EXT_BASE           = 32'h0000_0000,
   localparam int unsigned IDX_W = (NUM_SRAM_ADDRESSES > 1) ? $clog2(NUM_SRAM_ADDRESSES) : 1,
   localparam int unsigned CNT_W = $clog2(BLOCK_WORDS)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    swap_req_i,
   input  logic [IDX_W-1:0]        old_addr_idx_i,
   input  logic [BLOCK_ADDR_W-1:0] old_addr_i,
   input  logic [BLOCK_ADDR_W-1:0] new_addr_i,
   output logic                    done_o,
   output logic                    busy_o,
   output logic                    sram_req_o,
   output logic                    sram_we_o,
   output logic [31:0]             sram_addr_o,
   output logic [31:0]             sram_wdata_o,
   input  logic                    sram_gnt_i,
   input  logic                    sram_rvalid_i,
   input  logic [31:0]             sram_rdata_i,
   output logic                    ext_req_o,
   output logic                    ext_we_o,
   output logic [31:0]             ext_addr_o,
   output logic [31:0]             ext_wdata_o,
   input  logic                    ext_gnt_i,
   input  logic                    ext_rvalid_i,
   input  logic [31:0]             ext_rdata_i
);

   localparam logic [31:0]      SLOT_BYTES = 32'(BLOCK_WORDS * 4);
   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);

   swap_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [31:0]             buf_q, buf_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BLOCK_ADDR_W-1:0] old_q, old_d;
   logic [BLOCK_ADDR_W-1:0] new_q, new_d;

   logic [31:0] word_off;
   logic [31:0] slot_addr;
   logic [31:0] ext_old_addr;
   logic [31:0] ext_new_addr;
   logic        last_word;

   // All addressing uses the latched copies so mid-swap input changes cannot redirect accesses.
   assign word_off     = 32'(cnt_q) << 2;
   assign slot_addr    = SRAM_BASE + 32'(idx_q) * SLOT_BYTES + word_off;
   assign ext_old_addr = EXT_BASE + {old_q, BLOCK_OFFSET_W'(0)} + word_off;
   assign ext_new_addr = EXT_BASE + {new_q, BLOCK_OFFSET_W'(0)} + word_off;
   assign last_word    = (cnt_q == LAST_WORD);
   assign busy_o       = (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         idx_q   <= '0;
         old_q   <= '0;
         new_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         old_q   <= old_d;
         new_q   <= new_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      idx_d        = idx_q;
      old_d        = old_q;
      new_d        = new_q;
      done_o       = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      ext_req_o    = 1'b0;
      ext_we_o     = 1'b0;
      ext_addr_o   = '0;
      ext_wdata_o  = '0;

      unique case (state_q)
         IDLE: begin
            if (swap_req_i) begin
               idx_d   = old_addr_idx_i;
               old_d   = old_addr_i;
               new_d   = new_addr_i;
               // An empty slot has nothing worth writing back.
               state_d = (old_addr_i != INVALID_BLOCK_ADDR) ? WB_RD : FE_RD;
            end
         end
         WB_RD: begin
            sram_req_o  = 1'b1;
            sram_addr_o = slot_addr;
            if (sram_gnt_i) state_d = WB_RWAIT;
         end
         WB_RWAIT: begin
            if (sram_rvalid_i) begin
               buf_d   = sram_rdata_i;
               state_d = WB_WR;
            end
         end
         WB_WR: begin
            ext_req_o   = 1'b1;
            ext_we_o    = 1'b1;
            ext_addr_o  = ext_old_addr;
            ext_wdata_o = buf_q;
            if (ext_gnt_i) state_d = WB_WWAIT;
         end
         WB_WWAIT: begin
            if (ext_rvalid_i) begin
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = FE_RD;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = WB_RD;
               end
            end
         end
         FE_RD: begin
            ext_req_o  = 1'b1;
            ext_addr_o = ext_new_addr;
            if (ext_gnt_i) state_d = FE_RWAIT;
         end
         FE_RWAIT: begin
            if (ext_rvalid_i) begin
               buf_d   = ext_rdata_i;
               state_d = FE_WR;
            end
         end
         FE_WR: begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = slot_addr;
            sram_wdata_o = buf_q;
            if (sram_gnt_i) state_d = FE_WWAIT;
         end
         FE_WWAIT: begin
            if (sram_rvalid_i) begin
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = FE_RD;
               end
            end
         end
         DONE: begin
            // swap_req_i is deliberately ignored here: the blocker commits the tag on this
            // edge, so IDLE sees its updated request next cycle.
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_block_swap_engine.sv
module tb_block_swap_engine;
   import block_swap_engine_pkg::*;

   localparam int          BW = 512;
   localparam logic [31:0] SB = 32'h1000_0000;
   localparam logic [31:0] EB = 32'h0000_0000;

   logic        clk, rst_n, swap_req;
   logic [1:0]  idx;
   logic [20:0] old_blk, new_blk;
   logic        done, busy;
   logic        sram_req, sram_we, sram_gnt, sram_rvalid;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
   logic        ext_req, ext_we, ext_gnt, ext_rvalid;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;

   block_swap_engine #(
      .NUM_SRAM_ADDRESSES(4), .BLOCK_WORDS(BW), .SRAM_BASE(SB), .EXT_BASE(EB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .swap_req_i(swap_req),
      .old_addr_idx_i(idx), .old_addr_i(old_blk), .new_addr_i(new_blk),
      .done_o(done), .busy_o(busy),
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_gnt_i(sram_gnt), .sram_rvalid_i(sram_rvalid),
      .sram_rdata_i(sram_rdata),
      .ext_req_o(ext_req), .ext_we_o(ext_we), .ext_addr_o(ext_addr),
      .ext_wdata_o(ext_wdata), .ext_gnt_i(ext_gnt), .ext_rvalid_i(ext_rvalid),
      .ext_rdata_i(ext_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  kind;   // 0 sram access, 1 ext access, 2 done pulse
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] sram_mem[logic [31:0]];
   logic [31:0] ext_mem[logic [31:0]];
   logic [31:0] exp_sram[logic [31:0]];
   logic [31:0] exp_ext[logic [31:0]];

   int checks = 0, errors = 0;
   int max_stall = 0;
   int done_cnt = 0, ext_wr_cnt = 0, sram_wr_cnt = 0, sram_rd_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] sram_act(input logic [31:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : pat(a);
   endfunction
   function automatic logic [31:0] ext_act(input logic [31:0] a);
      return ext_mem.exists(a) ? ext_mem[a] : pat(a);
   endfunction
   function automatic logic [31:0] sram_exp(input logic [31:0] a);
      return exp_sram.exists(a) ? exp_sram[a] : pat(a);
   endfunction
   function automatic logic [31:0] ext_exp(input logic [31:0] a);
      return exp_ext.exists(a) ? exp_ext[a] : pat(a);
   endfunction

   function automatic logic [31:0] slot_base(input int i);
      return SB + 32'(i) * 32'(BW * 4);
   endfunction
   function automatic logic [31:0] blk_base(input logic [20:0] b);
      return EB + {b, 11'b0};
   endfunction

   // Expected bus sequence for one swap, computed against a shadow copy of both memories.
   task automatic push_swap(input int i, input logic [20:0] ob, input logic [20:0] nb);
      txn_t        t;
      logic [31:0] sa, ea;
      if (ob != INVALID_BLOCK_ADDR) begin
         for (int w = 0; w < BW; w++) begin
            sa = slot_base(i) + 32'(w) * 4;
            ea = blk_base(ob) + 32'(w) * 4;
            t = '{kind: 2'd0, we: 1'b0, addr: sa, wdata: 32'h0};
            exp_q.push_back(t);
            t = '{kind: 2'd1, we: 1'b1, addr: ea, wdata: sram_exp(sa)};
            exp_ext[ea] = t.wdata;
            exp_q.push_back(t);
         end
      end
      for (int w = 0; w < BW; w++) begin
         sa = slot_base(i) + 32'(w) * 4;
         ea = blk_base(nb) + 32'(w) * 4;
         t = '{kind: 2'd1, we: 1'b0, addr: ea, wdata: 32'h0};
         exp_q.push_back(t);
         t = '{kind: 2'd0, we: 1'b1, addr: sa, wdata: ext_exp(ea)};
         exp_sram[sa] = t.wdata;
         exp_q.push_back(t);
      end
      t = '{kind: 2'd2, we: 1'b0, addr: 32'h0, wdata: 32'h0};
      exp_q.push_back(t);
   endtask

   task automatic check_txn(input logic [1:0] kind, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      txn_t t;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_output: kind %0d addr %h with nothing expected", kind, addr);
      end else begin
         t = exp_q.pop_front();
         chk("txn_kind", 32'(kind), 32'(t.kind));
         if (t.kind != 2'd2) begin
            chk("txn_we", 32'(we), 32'(t.we));
            chk("txn_addr", addr, t.addr);
            if (t.we) chk("txn_wdata", wdata, t.wdata);
         end
      end
   endtask

   // Monitor: compares every accepted bus request and every done pulse against the queue.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (sram_req || ext_req)
               chk("port_exclusive", 32'(sram_req && ext_req), 32'h0);
            if (sram_req && sram_gnt) begin
               if (sram_we) sram_wr_cnt++;
               else sram_rd_cnt++;
               check_txn(2'd0, sram_we, sram_addr, sram_wdata);
            end
            if (ext_req && ext_gnt) begin
               if (ext_we) ext_wr_cnt++;
               check_txn(2'd1, ext_we, ext_addr, ext_wdata);
            end
            if (done) begin
               done_cnt++;
               check_txn(2'd2, 1'b0, 32'h0, 32'h0);
            end
         end
      end
   end

   // SRAM subordinate with optional grant/response stalls.
   initial begin
      logic [31:0] a, d;
      logic        w;
      int          n;
      sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 32'h0;
      @(negedge clk);
      forever begin
         if (!(sram_req && rst_n)) begin
            @(negedge clk);
         end else begin
            a = sram_addr; w = sram_we; d = sram_wdata;
            n = int'($urandom_range(max_stall, 0));
            repeat (n) begin
               @(negedge clk);
               chk("sram_req_stable", 32'(sram_req), 32'h1);
               chk("sram_addr_stable", sram_addr, a);
               chk("sram_we_stable", 32'(sram_we), 32'(w));
               chk("sram_wdata_stable", sram_wdata, d);
            end
            sram_gnt = 1'b1;
            @(negedge clk);
            sram_gnt = 1'b0;
            if (w) sram_mem[a] = d;
            n = int'($urandom_range(max_stall, 0));
            repeat (n) @(negedge clk);
            sram_rvalid = 1'b1;
            sram_rdata  = w ? 32'h0 : sram_act(a);
            @(negedge clk);
            sram_rvalid = 1'b0;
         end
      end
   end

   // External memory subordinate with optional grant/response stalls.
   initial begin
      logic [31:0] a, d;
      logic        w;
      int          n;
      ext_gnt = 1'b0; ext_rvalid = 1'b0; ext_rdata = 32'h0;
      @(negedge clk);
      forever begin
         if (!(ext_req && rst_n)) begin
            @(negedge clk);
         end else begin
            a = ext_addr; w = ext_we; d = ext_wdata;
            n = int'($urandom_range(max_stall, 0));
            repeat (n) begin
               @(negedge clk);
               chk("ext_req_stable", 32'(ext_req), 32'h1);
               chk("ext_addr_stable", ext_addr, a);
               chk("ext_we_stable", 32'(ext_we), 32'(w));
               chk("ext_wdata_stable", ext_wdata, d);
            end
            ext_gnt = 1'b1;
            @(negedge clk);
            ext_gnt = 1'b0;
            if (w) ext_mem[a] = d;
            n = int'($urandom_range(max_stall, 0));
            repeat (n) @(negedge clk);
            ext_rvalid = 1'b1;
            ext_rdata  = w ? 32'h0 : ext_act(a);
            @(negedge clk);
            ext_rvalid = 1'b0;
         end
      end
   end

   // Counts monitor samples until done_o is seen; an expired bound is a failed comparison.
   task automatic wait_done(input int limit, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < limit) begin
         step();
         n++;
         if (done) seen = 1'b1;
      end
      chk("done_within_bound", 32'(seen), 32'h1);
   endtask

   task automatic start_swap(input logic [1:0] i, input logic [20:0] ob, input logic [20:0] nb);
      idx = i; old_blk = ob; new_blk = nb; swap_req = 1'b1;
   endtask

   initial begin
      int n, base, base2, dc, k;
      rst_n = 1'b0; swap_req = 1'b0; idx = 2'd0; old_blk = 21'h0; new_blk = 21'h0;
      step(); step();
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_sram_req", 32'(sram_req), 32'h0);
      chk("rst_sram_we", 32'(sram_we), 32'h0);
      chk("rst_sram_addr", sram_addr, 32'h0);
      chk("rst_sram_wdata", sram_wdata, 32'h0);
      chk("rst_ext_req", 32'(ext_req), 32'h0);
      chk("rst_ext_we", 32'(ext_we), 32'h0);
      chk("rst_ext_addr", ext_addr, 32'h0);
      chk("rst_ext_wdata", ext_wdata, 32'h0);
      rst_n = 1'b1;
      step();

      // Full swap, zero-wait bus.
      base = sram_rd_cnt; base2 = ext_wr_cnt;
      push_swap(1, 21'h000004, 21'h000009);
      start_swap(2'd1, 21'h000004, 21'h000009);
      wait_done(20000, n);
      swap_req = 1'b0;
      chk("latency_full_swap", 32'(n + 1), 32'(8 * BW + 2));
      chk("full_sram_reads", 32'(sram_rd_cnt - base), 32'(BW));
      chk("full_ext_writes", 32'(ext_wr_cnt - base2), 32'(BW));
      step(); step();
      chk("idle_after_full", 32'(busy), 32'h0);

      // Empty slot: fetch only.
      base = sram_rd_cnt; base2 = ext_wr_cnt;
      push_swap(0, INVALID_BLOCK_ADDR, 21'h000003);
      start_swap(2'd0, INVALID_BLOCK_ADDR, 21'h000003);
      wait_done(20000, n);
      swap_req = 1'b0;
      chk("latency_empty_slot", 32'(n + 1), 32'(4 * BW + 2));
      chk("empty_no_sram_reads", 32'(sram_rd_cnt - base), 32'h0);
      chk("empty_no_ext_writes", 32'(ext_wr_cnt - base2), 32'h0);
      step(); step();

      // Random stalls on both ports; slot contents must equal the fetched block.
      max_stall = 5;
      push_swap(2, 21'h000010, 21'h000020);
      start_swap(2'd2, 21'h000010, 21'h000020);
      wait_done(60000, n);
      swap_req = 1'b0;
      step(); step();
      max_stall = 0;
      for (int w = 0; w < BW; w++)
         chk("stall_slot_data", sram_act(slot_base(2) + 32'(w) * 4),
             ext_act(blk_base(21'h000020) + 32'(w) * 4));

      // Request held through DONE restarts a second swap; dropping it stops further swaps.
      dc = done_cnt;
      push_swap(3, 21'h000030, 21'h000031);
      push_swap(3, 21'h000030, 21'h000031);
      start_swap(2'd3, 21'h000030, 21'h000031);
      wait_done(20000, n);
      step();
      chk("idle_after_done", 32'(busy), 32'h0);
      step();
      chk("restart_req_held", 32'(busy), 32'h1);
      wait_done(20000, n);
      swap_req = 1'b0;
      for (int j = 0; j < 4; j++) begin
         step();
         chk("no_double_swap", 32'(busy), 32'h0);
      end
      chk("held_req_done_count", 32'(done_cnt - dc), 32'h2);

      // Inputs change and request drops mid-fetch: latched values stay in use.
      dc = done_cnt; base = sram_wr_cnt;
      push_swap(0, 21'h000040, 21'h000041);
      start_swap(2'd0, 21'h000040, 21'h000041);
      k = 0;
      while ((sram_wr_cnt - base) < 10 && k < 20000) begin
         step();
         k++;
      end
      chk("reach_fetch_word10", 32'((sram_wr_cnt - base) >= 10), 32'h1);
      swap_req = 1'b0; idx = 2'd2; new_blk = 21'h000055; old_blk = 21'h000066;
      wait_done(20000, n);
      chk("drop_req_done_count", 32'(done_cnt - dc), 32'h1);
      step(); step();
      chk("idle_after_drop", 32'(busy), 32'h0);

      // Async reset at writeback word 200, then a clean restart.
      base2 = ext_wr_cnt;
      push_swap(2, 21'h000070, 21'h000071);
      start_swap(2'd2, 21'h000070, 21'h000071);
      k = 0;
      while ((ext_wr_cnt - base2) < 200 && k < 20000) begin
         step();
         k++;
      end
      chk("reach_wb_word200", 32'((ext_wr_cnt - base2) >= 200), 32'h1);
      k = 0;
      while (!sram_req && k < 20) begin
         step();
         k++;
      end
      chk("wb_word200_addr", sram_addr, slot_base(2) + 32'd800);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_sram_req", 32'(sram_req), 32'h0);
      chk("arst_sram_addr", sram_addr, 32'h0);
      chk("arst_ext_req", 32'(ext_req), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      exp_q.delete();
      swap_req = 1'b0;
      dc = done_cnt;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("no_done_after_reset", 32'(done_cnt), 32'(dc));
      push_swap(0, 21'h000074, 21'h000075);
      start_swap(2'd0, 21'h000074, 21'h000075);
      step();
      chk("restart_word0_addr", sram_addr, slot_base(0));
      wait_done(20000, n);
      swap_req = 1'b0;
      step(); step(); step();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
